button_debounce: RTL

- Input-side companion to the LED output logic: conditions one raw, asynchronous push-button or switch into clean, single-clock-domain events.
- Synchronises the raw input, then debounces it with a counter-based FSM.
- Emits a debounced level plus one-cycle press, release and long-press pulses, and a running press count.
- Sits between the board pin and any control logic, for example the blink-enable path.

---
 rtl/button_debounce_pkg.sv | 20 ++
 rtl/button_debounce_sync_2ff.sv | 26 ++
 rtl/button_debounce.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/button_debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
package button_debounce_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DEB_PRESS   = 3'd1,
        PRESSED     = 3'd2,
        HELD        = 3'd3,
        DEB_RELEASE = 3'd4
    } state_e;

    // Board defaults (100 MHz): 10 ms debounce, 1 s long press.
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int unsigned LONG_CYCLES_DEF     = 100000000;

    // Short intervals for simulation.
    localparam int unsigned DEBOUNCE_SIM = 4;
    localparam int unsigned LONG_SIM     = 20;

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// Two-flop synchroniser with a selectable reset value, for any raw pin.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,   // synchronous, active low
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronise, debounce, and emit level plus
// one-cycle press / release / long-press pulses and a press counter.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter int unsigned CNT_W           = 27,
    parameter logic        ACTIVE_LOW      = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,   // synchronous, active low
    input  logic       btn_in_i,
    output logic       level_o,
    output logic       press_o,
    output logic       release_o,
    output logic       long_press_o,
    output logic [7:0] press_count_o
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    logic pin_sync;
    logic s;

    // Flops reset to the idle pin value so reset release cannot look like a press.
    sync_2ff #(.RST_VAL(ACTIVE_LOW)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (btn_in_i),
        .q_o   (pin_sync)
    );

    assign s = pin_sync ^ ACTIVE_LOW;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic               long_done_q, long_done_d;
    logic               level_q, level_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               long_q, long_d;
    logic [7:0]         count_q, count_d;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        count_d     = count_q;
        unique case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = DEB_PRESS;
                    timer_d = '0;
                end
            end
            DEB_PRESS: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (timer_q == DEB_LAST) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    count_d = count_q + 8'd1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = DEB_RELEASE;
                    timer_d = '0;
                end else if (timer_q == LONG_LAST) begin
                    state_d     = HELD;
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = DEB_RELEASE;
                    timer_d = '0;
                end
            end
            DEB_RELEASE: begin
                // A rejected release glitch restarts the long-press interval.
                if (s) begin
                    state_d = long_done_q ? HELD : PRESSED;
                    timer_d = '0;
                end else if (timer_q == DEB_LAST) begin
                    state_d     = IDLE;
                    level_d     = 1'b0;
                    release_d   = 1'b1;
                    long_done_d = 1'b0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            count_q     <= count_d;
        end
    end

    assign level_o       = level_q;
    assign press_o       = press_q;
    assign release_o     = release_q;
    assign long_press_o  = long_q;
    assign press_count_o = count_q;

endmodule
